// File: rtl/cpu6502_timer_responder.sv
// Memory-mapped 16-bit interval timer for a 6502 external bus.
// Eight-byte register window at BASE_ADDR: control, status, reload value,
// a coherent count read (low byte snapshots the high byte), and an 8-bit
// prescaler. Raises an active-low level interrupt on expiry.
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   nReset      synchronous active-low reset
//   enable      clock enable shared with the CPU; all state holds when low
//   address     CPU address bus
//   writeData   CPU data-out bus
//   writeEnable CPU write strobe (1 = write, 0 = read)
//   readData    registered read data for the CPU data-in mux
//   selected    combinational window decode, steers the data-in mux
//   nIRQ        registered active-low interrupt
module cpu6502_timer_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hD000
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        enable,
  input  logic [15:0] address,
  input  logic [7:0]  writeData,
  input  logic        writeEnable,
  output logic [7:0]  readData,
  output logic        selected,
  output logic        nIRQ
);

  localparam int unsigned DataW  = 8;
  localparam int unsigned CountW = 16;
  localparam int unsigned OffW   = 3;
  localparam int unsigned PageW  = 16 - OffW;

  localparam logic [PageW-1:0] BasePage = BASE_ADDR[15:OffW];

  localparam logic [OffW-1:0] OffCtrl     = 3'd0;
  localparam logic [OffW-1:0] OffStatus   = 3'd1;
  localparam logic [OffW-1:0] OffReloadL  = 3'd2;
  localparam logic [OffW-1:0] OffReloadH  = 3'd3;
  localparam logic [OffW-1:0] OffCountL   = 3'd4;
  localparam logic [OffW-1:0] OffCountH   = 3'd5;
  localparam logic [OffW-1:0] OffPrescale = 3'd6;

  // Architectural state
  logic              run, oneShot, irqEn, expired;
  logic [CountW-1:0] reload, count;
  logic [DataW-1:0]  prescale, ps, snap;

  // Next-state values
  logic              runNext, oneShotNext, irqEnNext, expiredNext;
  logic [CountW-1:0] reloadNext, countNext;
  logic [DataW-1:0]  prescaleNext, psNext, snapNext, readDataNext;

  logic [OffW-1:0] offset;
  logic            busWrite, busRead, ctrlWrite, loadCount, tick, expiry;

  assign selected = (address[15:OffW] == BasePage);
  assign offset   = address[OffW-1:0];

  // Bus decode, prescaler, counter and register next-state
  always_comb begin
    runNext      = run;
    oneShotNext  = oneShot;
    irqEnNext    = irqEn;
    expiredNext  = expired;
    reloadNext   = reload;
    countNext    = count;
    prescaleNext = prescale;
    psNext       = ps;
    snapNext     = snap;
    readDataNext = readData;

    busWrite  = selected && writeEnable;
    busRead   = selected && !writeEnable;
    ctrlWrite = busWrite && (offset == OffCtrl);
    loadCount = busWrite && (offset == OffCountH);
    tick      = run && (ps == prescale);
    // A COUNT_H load swallows a coincident tick entirely
    expiry    = tick && (count == '0) && !loadCount;

    // Prescaler
    if (loadCount || !run || tick) begin
      psNext = '0;
    end else begin
      psNext = DataW'(ps + DataW'(1));
    end

    // Counter
    if (loadCount) begin
      countNext = reload;
    end else if (tick) begin
      if (count != '0) begin
        countNext = CountW'(count - CountW'(1));
      end else if (!oneShot) begin
        countNext = reload;
      end
    end

    // Register writes
    if (busWrite) begin
      case (offset)
        OffCtrl: begin
          runNext     = writeData[0];
          oneShotNext = writeData[1];
          irqEnNext   = writeData[2];
        end
        OffStatus: begin
          if (writeData[0]) begin
            expiredNext = 1'b0;
          end
        end
        OffReloadL:  reloadNext[7:0]  = writeData;
        OffReloadH:  reloadNext[15:8] = writeData;
        OffCountH:   expiredNext      = 1'b0;
        OffPrescale: prescaleNext     = writeData;
        default: ;
      endcase
    end

    // Expiry overrides a status clear; an explicit CTRL write overrides the
    // one-shot auto-stop
    if (expiry) begin
      expiredNext = 1'b1;
      if (oneShot && !ctrlWrite) begin
        runNext = 1'b0;
      end
    end

    // Register reads; only COUNT_L has a side effect (high-byte snapshot)
    if (busRead) begin
      case (offset)
        OffCtrl:     readDataNext = {5'b0, irqEn, oneShot, run};
        OffStatus:   readDataNext = {run, 6'b0, expired};
        OffReloadL:  readDataNext = reload[7:0];
        OffReloadH:  readDataNext = reload[15:8];
        OffCountL: begin
          readDataNext = count[7:0];
          snapNext     = count[15:8];
        end
        OffCountH:   readDataNext = snap;
        OffPrescale: readDataNext = prescale;
        default:     readDataNext = '0;
      endcase
    end
  end

  // State registers; enable gates everything except reset and nIRQ, which
  // simply follows the held flags
  always_ff @(posedge clock) begin
    if (!nReset) begin
      run      <= 1'b0;
      oneShot  <= 1'b0;
      irqEn    <= 1'b0;
      expired  <= 1'b0;
      reload   <= '0;
      count    <= '0;
      prescale <= '0;
      ps       <= '0;
      snap     <= '0;
      readData <= '0;
      nIRQ     <= 1'b1;
    end else begin
      if (enable) begin
        run      <= runNext;
        oneShot  <= oneShotNext;
        irqEn    <= irqEnNext;
        expired  <= expiredNext;
        reload   <= reloadNext;
        count    <= countNext;
        prescale <= prescaleNext;
        ps       <= psNext;
        snap     <= snapNext;
        readData <= readDataNext;
      end
      nIRQ <= !(expired && irqEn);
    end
  end

endmodule

// File: tb/tb_cpu6502_timer_responder.sv
// Table-driven bench for cpu6502_timer_responder. Each table row is one bus
// cycle; expectations are queued when the row is driven and compared after
// the rising edge that produces them.
module tb_cpu6502_timer_responder;

  localparam logic [15:0] Base = 16'hD000;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  writeData = '0;
  logic        writeEnable = 1'b0;
  logic [7:0]  readData;
  logic        selected;
  logic        nIRQ;

  int nTests = 0;
  int nFail  = 0;

  cpu6502_timer_responder #(.BASE_ADDR(Base)) dut (
    .clock       (clock),
    .nReset      (nReset),
    .enable      (enable),
    .address     (address),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .readData    (readData),
    .selected    (selected),
    .nIRQ        (nIRQ)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        nRst;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        chkRd;
    logic [7:0]  expRd;
    logic        expIrqN;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t pending[$];

  function automatic void add(logic nRst, logic en, logic we, logic [15:0] addr,
                              logic [7:0] wd, logic chkRd, logic [7:0] expRd,
                              logic expIrqN, string name);
    vec_t v;
    v.nRst = nRst; v.en = en; v.we = we; v.addr = addr; v.wd = wd;
    v.chkRd = chkRd; v.expRd = expRd; v.expIrqN = expIrqN; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void rst(string name);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b1, name);
  endfunction
  function automatic void wr(logic [2:0] off, logic [7:0] d, logic irqN, string name);
    add(1'b1, 1'b1, 1'b1, Base + 16'(off), d, 1'b0, 8'h00, irqN, name);
  endfunction
  function automatic void rd(logic [2:0] off, logic [7:0] exp, logic irqN, string name);
    add(1'b1, 1'b1, 1'b0, Base + 16'(off), 8'h00, 1'b1, exp, irqN, name);
  endfunction
  function automatic void idle(logic irqN, string name);
    add(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, irqN, name);
  endfunction

  function automatic void check(string name, int idx, string what, logic [15:0] act,
                                logic [15:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s[%0d] %s got %h expected %h", name, idx, what, act, exp);
    end
  endfunction

  initial begin
    // Power-up reset
    rst("por"); rst("por");

    // Continuous, RELOAD=3, PRESCALE=0, IRQEN: expiry every 4 cycles
    wr(3'd2, 8'h03, 1, "cont_cfg"); wr(3'd3, 8'h00, 1, "cont_cfg");
    wr(3'd6, 8'h00, 1, "cont_cfg"); wr(3'd5, 8'h00, 1, "cont_load");
    wr(3'd0, 8'h05, 1, "cont_start");
    idle(1, "cont_run"); idle(1, "cont_run"); idle(1, "cont_run");
    rd(3'd1, 8'h80, 1, "cont_pre_exp");
    rd(3'd1, 8'h81, 0, "cont_exp1");
    wr(3'd1, 8'h01, 0, "cont_clr");
    idle(1, "cont_irq_release");
    rd(3'd1, 8'h80, 1, "cont_pre_exp2");
    rd(3'd1, 8'h81, 0, "cont_exp2");
    wr(3'd1, 8'h01, 0, "cont_clr2");
    rd(3'd1, 8'h80, 1, "cont_cleared");
    wr(3'd1, 8'h01, 1, "coll_clr_on_exp");
    rd(3'd1, 8'h81, 0, "coll_set_wins");
    rd(3'd4, 8'h02, 0, "cont_count");

    // Reset mid-run, enable low during the reset edge
    rst("mid_reset");
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, 1, "reset_reads");

    // One-shot, RELOAD=2, PRESCALE=1: expires 6 cycles after start
    wr(3'd2, 8'h02, 1, "os_cfg"); wr(3'd6, 8'h01, 1, "os_cfg");
    wr(3'd5, 8'h00, 1, "os_load");
    wr(3'd0, 8'h03, 1, "os_start");
    for (int i = 0; i < 5; i++) idle(1, "os_run");
    rd(3'd1, 8'h80, 1, "os_pre_exp");
    rd(3'd1, 8'h01, 1, "os_expired");
    rd(3'd4, 8'h00, 1, "os_count_l");
    rd(3'd5, 8'h00, 1, "os_count_h");
    rd(3'd0, 8'h02, 1, "os_stopped");

    // COUNT_H write on a tick: load wins (RELOAD=5, PRESCALE=1)
    wr(3'd2, 8'h05, 1, "ld_cfg"); wr(3'd5, 8'h00, 1, "ld_load");
    wr(3'd0, 8'h01, 1, "ld_start");
    idle(1, "ld_run"); idle(1, "ld_run");
    rd(3'd4, 8'h04, 1, "ld_count4");
    wr(3'd5, 8'h00, 1, "ld_on_tick");
    rd(3'd4, 8'h05, 1, "ld_wins");
    rd(3'd4, 8'h05, 1, "ld_hold");
    rd(3'd4, 8'h04, 1, "ld_dec");

    // Enable low for 10 cycles with a COUNT_H write on the bus: nothing moves
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, 1'b1, Base + 16'd5, 8'h00, 1'b1, 8'h04, 1'b1, "en_low_hold");
    rd(3'd4, 8'h04, 1, "en_resume");
    rd(3'd4, 8'h03, 1, "en_resume");
    rd(3'd4, 8'h03, 1, "en_resume");

    // Decode: BASE+8 write and BASE+12 read are outside the window
    add(1'b1, 1'b1, 1'b1, Base + 16'd8, 8'h00, 1'b0, 8'h00, 1'b1, "dec_wr_out");
    add(1'b1, 1'b1, 1'b0, Base + 16'd12, 8'h00, 1'b1, 8'h03, 1'b1, "dec_rd_out");
    rd(3'd4, 8'h01, 1, "dec_count");
    rd(3'd0, 8'h01, 1, "dec_ctrl_kept");

    // Coherent 16-bit read across a borrow (COUNT=0100, continuous)
    rst("coh_reset");
    wr(3'd2, 8'h00, 1, "coh_cfg"); wr(3'd3, 8'h01, 1, "coh_cfg");
    wr(3'd5, 8'h00, 1, "coh_load");
    wr(3'd0, 8'h01, 1, "coh_start");
    rd(3'd4, 8'h00, 1, "coh_low");
    rd(3'd5, 8'h01, 1, "coh_snap");
    rd(3'd4, 8'hFE, 1, "coh_low2");
    rd(3'd5, 8'h00, 1, "coh_snap2");

    // CTRL write on the one-shot expiry cycle: written RUN wins
    rst("ctl_reset");
    wr(3'd2, 8'h01, 1, "ctl_cfg"); wr(3'd5, 8'h00, 1, "ctl_load");
    wr(3'd0, 8'h03, 1, "ctl_start");
    idle(1, "ctl_run");
    wr(3'd0, 8'h03, 1, "ctl_on_exp");
    rd(3'd0, 8'h03, 1, "ctl_run_kept");
    rd(3'd0, 8'h02, 1, "ctl_stopped");

    foreach (vecs[i]) begin
      vec_t v;
      vec_t e;
      logic expSel;
      v = vecs[i];
      @(negedge clock);
      nReset      = v.nRst;
      enable      = v.en;
      writeEnable = v.we;
      address     = v.addr;
      writeData   = v.wd;
      pending.push_back(v);
      #1;
      expSel = (v.addr >= Base) && (v.addr <= Base + 16'd7);
      check(v.name, i, "selected", 16'(selected), 16'(expSel));
      @(posedge clock);
      #1;
      e = pending.pop_front();
      if (e.chkRd) check(e.name, i, "readData", 16'(readData), 16'(e.expRd));
      check(e.name, i, "nIRQ", 16'(nIRQ), 16'(e.expIrqN));
    end

    if (pending.size() != 0) begin
      nTests++;
      nFail++;
      $display("FAIL scoreboard leftover got %0d expected 0", pending.size());
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
